// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the external multiplexed memory bus controller.
package mem_bus_pkg;

  localparam int unsigned BUS_W = 16;
  localparam logic [BUS_W-1:0] RDATA_ABORT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } bus_state_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module mem_arb_rr2 (
  input  logic       Req0,
  input  logic       Req1,
  input  logic       LastGnt,
  output logic [1:0] Grant
);

  always_comb begin
    Grant = '0;
    if (Req0 && Req1) begin
      Grant = LastGnt ? 2'b01 : 2'b10;
    end else if (Req0) begin
      Grant = 2'b01;
    end else if (Req1) begin
      Grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the multiplexed external memory bus between the core (port 0) and a
// secondary master (port 1): round-robin arbitration, address/data phases, nWait timeout.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [BUS_W-1:0] Addr0,
  input  logic [BUS_W-1:0] Addr1,
  input  logic [BUS_W-1:0] Wdata0,
  input  logic [BUS_W-1:0] Wdata1,
  input  logic             Write0,
  input  logic             Write1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Ack0,
  output logic             Ack1,
  output logic [BUS_W-1:0] Rdata,
  output logic             Timeout,
  output logic [BUS_W-1:0] BusOut,
  input  logic [BUS_W-1:0] BusIn,
  output logic             ALE,
  output logic             nME,
  output logic             nOE,
  output logic             RnW,
  output logic             ENB,
  input  logic             nWait
);

  bus_state_t       state, nextState;
  logic [1:0]       pick;
  logic             owner;
  logic             lastGnt;
  logic [BUS_W-1:0] addrQ;
  logic [BUS_W-1:0] wdataQ;
  logic             writeQ;
  logic [7:0]       waitCnt;
  logic             abortQ;
  logic             waitDone;

  mem_arb_rr2 arb (
    .Req0    (Req0),
    .Req1    (Req1),
    .LastGnt (lastGnt),
    .Grant   (pick)
  );

  // Counter holds the number of low nWait samples already taken in DATA.
  assign waitDone = (waitCnt == 8'(WAIT_MAX - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (Req0 || Req1) nextState = ADDR;
      ADDR: nextState = DATA;
      DATA: if (nWait || waitDone) nextState = DONE;
      DONE: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      owner   <= 1'b0;
      lastGnt <= 1'b1;
      addrQ   <= '0;
      wdataQ  <= '0;
      writeQ  <= 1'b0;
      waitCnt <= '0;
      abortQ  <= 1'b0;
      Rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            owner  <= pick[1];
            addrQ  <= pick[0] ? Addr0  : Addr1;
            wdataQ <= pick[0] ? Wdata0 : Wdata1;
            writeQ <= pick[0] ? Write0 : Write1;
            abortQ <= 1'b0;
          end
        end
        ADDR: waitCnt <= '0;
        DATA: begin
          if (nWait) begin
            if (!writeQ) Rdata <= BusIn;
          end else if (waitDone) begin
            abortQ <= 1'b1;
            if (!writeQ) Rdata <= RDATA_ABORT;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        DONE: lastGnt <= owner;
      endcase
    end
  end

  // Outputs decode only from flops, so no input reaches a pad combinationally.
  always_comb begin
    ALE     = 1'b0;
    nME     = 1'b1;
    nOE     = 1'b1;
    RnW     = 1'b1;
    ENB     = 1'b0;
    BusOut  = '0;
    Gnt0    = 1'b0;
    Gnt1    = 1'b0;
    Ack0    = 1'b0;
    Ack1    = 1'b0;
    Timeout = 1'b0;
    if (state != IDLE) begin
      Gnt0 = !owner;
      Gnt1 = owner;
    end
    unique case (state)
      IDLE: ;
      ADDR: begin
        ALE    = 1'b1;
        ENB    = 1'b1;
        BusOut = addrQ;
      end
      DATA: begin
        nME = 1'b0;
        if (writeQ) begin
          RnW    = 1'b0;
          ENB    = 1'b1;
          BusOut = wdataQ;
        end else begin
          nOE = 1'b0;
        end
      end
      DONE: begin
        Ack0    = !owner;
        Ack1    = owner;
        Timeout = abortQ;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed access table, reset/contention sequences,
// and randomized traffic against a transaction-schedule reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned WAIT_MAX = 15;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req0, Req1;
  logic [15:0] Addr0, Addr1, Wdata0, Wdata1;
  logic        Write0, Write1;
  logic        Gnt0, Gnt1, Ack0, Ack1, Timeout;
  logic [15:0] Rdata, BusOut, BusIn;
  logic        ALE, nME, nOE, RnW, ENB, nWait;

  mem_bus_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Req1(Req1),
    .Addr0(Addr0), .Addr1(Addr1),
    .Wdata0(Wdata0), .Wdata1(Wdata1),
    .Write0(Write0), .Write1(Write1),
    .Gnt0(Gnt0), .Gnt1(Gnt1),
    .Ack0(Ack0), .Ack1(Ack1),
    .Rdata(Rdata), .Timeout(Timeout),
    .BusOut(BusOut), .BusIn(BusIn),
    .ALE(ALE), .nME(nME), .nOE(nOE), .RnW(RnW), .ENB(ENB),
    .nWait(nWait)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oneHot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic cycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic applyReset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        write;
    logic [15:0] busIn;
    int          waits;
    int          dropAt;
    int          expLat;
    logic [15:0] expRd;
    logic        expTo;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] lastRd;

  task automatic runVec(input int idx, input vec_t v);
    int lat;
    bit acked;
    lat   = 0;
    acked = 0;
    BusIn = v.busIn;
    nWait = 1'b1;
    if (v.port) begin
      Addr1 = v.addr; Wdata1 = v.wdata; Write1 = v.write; Req1 = 1'b1;
    end else begin
      Addr0 = v.addr; Wdata0 = v.wdata; Write0 = v.write; Req0 = 1'b1;
    end
    for (int i = 1; i <= 40 && !acked; i++) begin
      cycle();
      if (i == 1) begin
        chk($sformatf("v%0d_addr_strobes", idx), {ALE, nME, nOE, RnW, ENB}, 5'b11111);
        chk($sformatf("v%0d_addr_bus", idx), BusOut, v.addr);
        chk($sformatf("v%0d_addr_gnt", idx), {Gnt1, Gnt0}, oneHot(v.port));
      end else if (i < v.expLat) begin
        chk($sformatf("v%0d_data_strobes_c%0d", idx, i), {ALE, nME, nOE, RnW, ENB},
            {1'b0, 1'b0, v.write, !v.write, v.write});
        chk($sformatf("v%0d_data_rdata_hold_c%0d", idx, i), Rdata, lastRd);
        if (v.write) chk($sformatf("v%0d_data_bus_c%0d", idx, i), BusOut, v.wdata);
      end
      if (Ack0 || Ack1) begin
        acked = 1;
        lat   = i;
        chk($sformatf("v%0d_ack_port", idx), {Ack1, Ack0}, oneHot(v.port));
        chk($sformatf("v%0d_rdata", idx), Rdata, v.expRd);
        chk($sformatf("v%0d_timeout", idx), Timeout, v.expTo);
        chk($sformatf("v%0d_done_gnt", idx), {Gnt1, Gnt0}, oneHot(v.port));
      end
      if (v.dropAt == i) begin
        if (v.port) Req1 = 1'b0; else Req0 = 1'b0;
      end
      nWait = !(i >= 2 && (i - 1) <= v.waits);
    end
    Req0  = 1'b0;
    Req1  = 1'b0;
    nWait = 1'b1;
    chk($sformatf("v%0d_latency", idx), lat, v.expLat);
    cycle();
    chk($sformatf("v%0d_no_extra_ack", idx), {Ack1, Ack0, Gnt1, Gnt0}, 4'b0000);
    cycle();
    lastRd = v.expRd;
  endtask

  // Reference model state for the random phase: one scheduled access at a time.
  logic        rq[2];
  logic [15:0] ra[2], rw[2];
  logic        rwr[2];
  bit          mActive, mLast, mOwn, mWr, mTo;
  int          mS, mW, mDC, mFree;
  logic [15:0] mAddr, mWdata, mRd, mRdExp;

  initial begin
    int ackCyc[4];
    logic ackPort[4];
    int n, overlap, lat;
    logic firstPort;

    Reset = 1'b1;
    Req0 = 0; Req1 = 0; Write0 = 0; Write1 = 0;
    Addr0 = '0; Addr1 = '0; Wdata0 = '0; Wdata1 = '0;
    BusIn = '0; nWait = 1'b1;

    vecs[0] = '{port:0, addr:16'h0040, wdata:16'h0000, write:0, busIn:16'hBEEF, waits:0,  dropAt:0, expLat:3,  expRd:16'hBEEF, expTo:0};
    vecs[1] = '{port:1, addr:16'h1234, wdata:16'h00A5, write:1, busIn:16'h0000, waits:3,  dropAt:0, expLat:6,  expRd:16'hBEEF, expTo:0};
    vecs[2] = '{port:0, addr:16'h0100, wdata:16'h0000, write:0, busIn:16'h1111, waits:99, dropAt:0, expLat:17, expRd:16'hFFFF, expTo:1};
    vecs[3] = '{port:0, addr:16'h0200, wdata:16'h0000, write:0, busIn:16'h5A5A, waits:1,  dropAt:0, expLat:4,  expRd:16'h5A5A, expTo:0};
    vecs[4] = '{port:1, addr:16'h0300, wdata:16'h7777, write:1, busIn:16'h0000, waits:99, dropAt:0, expLat:17, expRd:16'h5A5A, expTo:1};
    vecs[5] = '{port:1, addr:16'h0400, wdata:16'h0000, write:0, busIn:16'h0F0F, waits:14, dropAt:0, expLat:17, expRd:16'h0F0F, expTo:0};
    vecs[6] = '{port:0, addr:16'h0500, wdata:16'h0000, write:0, busIn:16'hC3C3, waits:2,  dropAt:2, expLat:5,  expRd:16'hC3C3, expTo:0};

    applyReset();
    chk("reset_ctl", {ALE, nME, nOE, RnW, ENB, Gnt0, Gnt1, Ack0, Ack1, Timeout}, 10'b0111000000);
    chk("reset_busout", BusOut, 16'h0000);
    chk("reset_rdata", Rdata, 16'h0000);
    lastRd = 16'h0000;

    for (int k = 0; k < 7; k++) runVec(k, vecs[k]);

    // Reset during DATA; last completed grant was port 0, so only reset makes port 0 win the tie.
    Addr0 = 16'h0600; Write0 = 1'b0; Req0 = 1'b1; nWait = 1'b0;
    repeat (3) cycle();
    Reset = 1'b1;
    cycle();
    chk("rstmid_ctl", {ALE, nME, nOE, ENB, Gnt0, Gnt1, Ack0, Ack1, Timeout}, 9'b011000000);
    chk("rstmid_rdata", Rdata, 16'h0000);
    Addr1 = 16'h0700; Write1 = 1'b0; Req1 = 1'b1; nWait = 1'b1; BusIn = 16'h2468;
    cycle();
    Reset = 1'b0;
    lat = 0;
    firstPort = 1'b1;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      cycle();
      if (Ack0 || Ack1) begin
        lat = c;
        firstPort = Ack1;
        Req0 = 1'b0;
        Req1 = 1'b0;
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    chk("rstmid_first_port", firstPort, 1'b0);
    chk("rstmid_latency", lat, 3);
    chk("rstmid_rdata_after", Rdata, 16'h2468);
    repeat (2) cycle();

    // Continuous contention from reset.
    Addr0 = 16'h0A00; Write0 = 1'b0; Addr1 = 16'h0B00; Wdata1 = 16'h5555; Write1 = 1'b1;
    Req0 = 1'b1; Req1 = 1'b1; nWait = 1'b1;
    applyReset();
    n = 0;
    overlap = 0;
    for (int k = 0; k < 4; k++) begin ackCyc[k] = 0; ackPort[k] = 1'bx; end
    for (int c = 1; c <= 60 && n < 4; c++) begin
      cycle();
      if (Gnt0 && Gnt1) overlap++;
      if (Ack0 || Ack1) begin
        ackCyc[n]  = c;
        ackPort[n] = Ack1;
        n++;
        if (n == 4) begin Req0 = 1'b0; Req1 = 1'b0; end
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    chk("cont_ack_count", n, 4);
    chk("cont_first_ack_cycle", ackCyc[0], 3);
    for (int k = 0; k < 4; k++) chk($sformatf("cont_order_%0d", k), ackPort[k], k[0]);
    for (int k = 1; k < 4; k++) chk($sformatf("cont_gap_%0d", k), ackCyc[k] - ackCyc[k-1], 4);
    chk("cont_gnt_overlap", overlap, 0);
    repeat (2) cycle();

    // Randomized traffic against the schedule model.
    Req0 = 1'b0; Req1 = 1'b0;
    applyReset();
    rq[0] = 0; rq[1] = 0;
    mActive = 0; mLast = 1; mFree = 0; mS = 0; mDC = 0; mW = 0;
    mOwn = 0; mWr = 0; mTo = 0; mAddr = '0; mWdata = '0; mRd = '0; mRdExp = '0;
    for (int e = 0; e < 3000; e++) begin
      int rel;
      bit act, busChk;
      logic [9:0] eCtl;
      logic [15:0] eBus;
      rel = e - mS;
      act = mActive && rel >= 0 && rel <= mDC + 1;
      eCtl = 10'b0111000000; // ALE nME nOE RnW ENB Gnt0 Gnt1 Ack0 Ack1 Timeout
      busChk = 0;
      eBus = '0;
      if (act) begin
        eCtl[4] = !mOwn;
        eCtl[3] = mOwn;
        if (rel == 0) begin
          eCtl[9] = 1'b1; eCtl[5] = 1'b1;
          busChk = 1; eBus = mAddr;
        end else if (rel <= mDC) begin
          eCtl[8] = 1'b0;
          if (mWr) begin
            eCtl[6] = 1'b0; eCtl[5] = 1'b1;
            busChk = 1; eBus = mWdata;
          end else begin
            eCtl[7] = 1'b0;
          end
        end else begin
          eCtl[2] = !mOwn;
          eCtl[1] = mOwn;
          eCtl[0] = mTo;
          if (!mWr) mRd = mTo ? 16'hFFFF : mRdExp;
        end
      end
      chk($sformatf("rnd_c%0d_ctl_rdata", e),
          {6'b0, ALE, nME, nOE, RnW, ENB, Gnt0, Gnt1, Ack0, Ack1, Timeout, Rdata},
          {6'b0, eCtl, mRd});
      if (busChk) chk($sformatf("rnd_c%0d_busout", e), BusOut, eBus);

      if (act && rel == mDC + 1) rq[mOwn] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] && $urandom_range(0, 2) == 0) begin
          rq[p]  = 1'b1;
          ra[p]  = 16'($urandom);
          rw[p]  = 16'($urandom);
          rwr[p] = 1'($urandom);
        end
      end

      if ((!mActive || e + 1 >= mFree) && (rq[0] || rq[1])) begin
        mOwn    = (rq[0] && rq[1]) ? !mLast : rq[1];
        mLast   = mOwn;
        mS      = e + 1;
        mAddr   = ra[mOwn];
        mWdata  = rw[mOwn];
        mWr     = rwr[mOwn];
        mW      = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(13, 17));
        mTo     = (mW >= int'(WAIT_MAX));
        mDC     = mTo ? int'(WAIT_MAX) : mW + 1;
        mFree   = mS + mDC + 3;
        mActive = 1;
      end

      Req0 = rq[0]; Addr0 = ra[0]; Wdata0 = rw[0]; Write0 = rwr[0];
      Req1 = rq[1]; Addr1 = ra[1]; Wdata1 = rw[1]; Write1 = rwr[1];
      BusIn = 16'($urandom);
      nWait = 1'b1;
      rel = e - mS;
      if (mActive && rel >= 1 && rel <= mDC) begin
        nWait = (rel > mW);
        if (rel == mDC && !mTo) mRdExp = BusIn;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
